// File: rtl/button_cmd_scheduler.sv
// Purpose: turn per-button release pulses into serialized req/ack commands, shared round-robin.
// Latency: pulse at edge t -> pending at t+1 -> cmd_req at t+2 when idle and enabled.
// Backpressure: one command in flight; repeat pulses coalesce in pending, timeout drops a stuck command.
module button_cmd_scheduler #(
  parameter int N_BTN   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_pulse,
  input  logic             enable,
  input  logic             cmd_ack,
  output logic             cmd_req,
  output logic [ID_W-1:0]  cmd_id,
  output logic [N_BTN-1:0] pending,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_BTN - 1);
  localparam logic [TW-1:0]    CNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [N_BTN-1:0] ONE_HOT0 = {{(N_BTN-1){1'b0}}, 1'b1};

  logic [0:0]       state;
  logic [ID_W-1:0]  last;
  logic [TW-1:0]    counter;

  logic             found;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  cand;
  logic             grant;
  logic [N_BTN-1:0] clr_vec;
  logic [N_BTN-1:0] pending_nxt;
  logic             overrun_nxt;

  // Round-robin search: first pending button after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = ID_W'((int'(last) + k) % N_BTN);
      if (!found && pending[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // A grant clears its pending bit on the same edge; a pulse landing on that
  // edge re-arms the bit and is not an overrun, since the old request is gone.
  always_comb begin
    grant       = (state == ST_IDLE) && enable && found;
    clr_vec     = grant ? (ONE_HOT0 << win) : '0;
    pending_nxt = (pending & ~clr_vec) | btn_pulse;
    overrun_nxt = |(btn_pulse & pending & ~clr_vec);
  end

  // Pending flags and overrun pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= pending_nxt;
      overrun <= overrun_nxt;
    end
  end

  // Command channel FSM: grant in IDLE, hold the request in WAIT until ack or timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cmd_req     <= 1'b0;
      cmd_id      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      counter     <= '0;
      last        <= LAST_RST;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            cmd_id  <= win;
            cmd_req <= 1'b1;
            busy    <= 1'b1;
            last    <= win;
            counter <= '0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          counter <= counter + 1'b1;
          // Ack takes precedence over a timeout expiring on the same edge.
          if (cmd_ack) begin
            cmd_req <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (counter == CNT_LAST) begin
            cmd_req     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_cmd_scheduler.sv
module tb_button_cmd_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] btn_pulse;
  logic       enable;
  logic       cmd_ack;
  logic       cmd_req;
  logic [1:0] cmd_id;
  logic [3:0] pending;
  logic       busy;
  logic       overrun;
  logic       timeout_err;

  int checks;
  int failures;

  button_cmd_scheduler #(
    .N_BTN(4), .ID_W(2), .TIMEOUT(5), .TW(8)
  ) dut (
    .clk(clk), .reset(reset), .btn_pulse(btn_pulse), .enable(enable),
    .cmd_ack(cmd_ack), .cmd_req(cmd_req), .cmd_id(cmd_id), .pending(pending),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    btn_pulse = 4'b0000;
    enable    = 1'b1;
    cmd_ack   = 1'b0;
    #2;
    step();

    // Reset state
    chk("rst_cmd_req", 32'(cmd_req), 32'd0);
    chk("rst_cmd_id", 32'(cmd_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b1;
    step();

    // 1: single pulse on button 2, two-cycle latency to cmd_req
    btn_pulse = 4'b0100;
    step();
    btn_pulse = 4'b0000;
    chk("t1_pending_set", 32'(pending), 32'h4);
    chk("t1_req_not_yet", 32'(cmd_req), 32'd0);
    step();
    chk("t1_req", 32'(cmd_req), 32'd1);
    chk("t1_id", 32'(cmd_id), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_pending_clr", 32'(pending), 32'd0);
    step();
    chk("t1_req_held", 32'(cmd_req), 32'd1);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    chk("t1_req_fall", 32'(cmd_req), 32'd0);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_pending_end", 32'(pending), 32'd0);

    // 2: all four buttons at once, served 0,1,2,3 with one idle cycle between
    do_reset();
    btn_pulse = 4'b1111;
    step();
    btn_pulse = 4'b0000;
    chk("t2_pending_all", 32'(pending), 32'hF);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", 32'(cmd_req), 32'd1);
      chk("t2_id", 32'(cmd_id), 32'(i));
      chk("t2_pending", 32'(pending), 32'((4'b1111 << (i + 1)) & 4'b1111));
      cmd_ack = 1'b1;
      step();
      cmd_ack = 1'b0;
      chk("t2_req_gap", 32'(cmd_req), 32'd0);
      step();
    end
    chk("t2_done_req", 32'(cmd_req), 32'd0);

    // 3: after granting button 2, pending 0101 wraps to button 0 then 2
    btn_pulse = 4'b0100;
    step();
    btn_pulse = 4'b0000;
    step();
    chk("t3_first_id", 32'(cmd_id), 32'd2);
    btn_pulse = 4'b0101;
    step();
    btn_pulse = 4'b0000;
    chk("t3_pending", 32'(pending), 32'h5);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    step();
    chk("t3_wrap_req", 32'(cmd_req), 32'd1);
    chk("t3_wrap_id", 32'(cmd_id), 32'd0);
    chk("t3_wrap_pending", 32'(pending), 32'h4);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    step();
    chk("t3_second_id", 32'(cmd_id), 32'd2);
    chk("t3_second_req", 32'(cmd_req), 32'd1);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;

    // 4: repeated pulses on pending button 1 while disabled
    enable = 1'b0;
    btn_pulse = 4'b0010;
    step();
    btn_pulse = 4'b0000;
    chk("t4_pending", 32'(pending), 32'h2);
    chk("t4_no_ovr_first", 32'(overrun), 32'd0);
    step();
    btn_pulse = 4'b0010;
    step();
    btn_pulse = 4'b0000;
    chk("t4_ovr1", 32'(overrun), 32'd1);
    step();
    chk("t4_ovr1_end", 32'(overrun), 32'd0);
    btn_pulse = 4'b0010;
    step();
    btn_pulse = 4'b0000;
    chk("t4_ovr2", 32'(overrun), 32'd1);
    step();
    chk("t4_ovr2_end", 32'(overrun), 32'd0);
    chk("t4_blocked", 32'(cmd_req), 32'd0);
    enable = 1'b1;
    step();
    chk("t4_req", 32'(cmd_req), 32'd1);
    chk("t4_id", 32'(cmd_id), 32'd1);
    chk("t4_pending_clr", 32'(pending), 32'd0);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    step();
    chk("t4_single_cmd", 32'(cmd_req), 32'd0);

    // 4b: pulse coinciding with the grant of the same button re-arms it, no overrun
    btn_pulse = 4'b0010;
    step();
    step();
    btn_pulse = 4'b0000;
    chk("t4b_id", 32'(cmd_id), 32'd1);
    chk("t4b_pending_kept", 32'(pending), 32'h2);
    chk("t4b_no_ovr", 32'(overrun), 32'd0);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    step();
    chk("t4b_regrant_req", 32'(cmd_req), 32'd1);
    chk("t4b_regrant_id", 32'(cmd_id), 32'd1);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;

    // 5: timeout after 5 cycles with no ack, then next pending button (last=1 -> 2, then 0)
    btn_pulse = 4'b0101;
    step();
    btn_pulse = 4'b0000;
    step();
    chk("t5_req", 32'(cmd_req), 32'd1);
    chk("t5_id", 32'(cmd_id), 32'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_req_hold", 32'(cmd_req), 32'd1);
      chk("t5_no_to", 32'(timeout_err), 32'd0);
    end
    step();
    chk("t5_req_drop", 32'(cmd_req), 32'd0);
    chk("t5_to_pulse", 32'(timeout_err), 32'd1);
    chk("t5_busy_drop", 32'(busy), 32'd0);
    step();
    chk("t5_to_end", 32'(timeout_err), 32'd0);
    chk("t5_next_req", 32'(cmd_req), 32'd1);
    chk("t5_next_id", 32'(cmd_id), 32'd0);
    // ack on the same edge the timeout would fire: ack wins
    for (int i = 0; i < 4; i++) step();
    chk("t5b_req_hold", 32'(cmd_req), 32'd1);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    chk("t5b_req_drop", 32'(cmd_req), 32'd0);
    chk("t5b_no_to", 32'(timeout_err), 32'd0);

    // 6: async reset mid-WAIT with pending 1010
    btn_pulse = 4'b0001;
    step();
    btn_pulse = 4'b0000;
    step();
    chk("t6_req", 32'(cmd_req), 32'd1);
    chk("t6_id", 32'(cmd_id), 32'd0);
    btn_pulse = 4'b1010;
    step();
    btn_pulse = 4'b0000;
    chk("t6_pending", 32'(pending), 32'hA);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_req", 32'(cmd_req), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_pending", 32'(pending), 32'd0);
    step();
    reset = 1'b1;
    btn_pulse = 4'b1001;
    step();
    btn_pulse = 4'b0000;
    step();
    chk("t6_prio_req", 32'(cmd_req), 32'd1);
    chk("t6_prio_id", 32'(cmd_id), 32'd0);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    step();
    chk("t6_next_id", 32'(cmd_id), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
